compressed_stream_capture: RTL and testbench

- Sits on the output side of the image compressor core.
- Takes the compressor's byte stream (data + valid strobe), its final size report and its done pulse, and stores the bytes in an internal buffer.
- Checks the stored byte count against the reported size, then plays the buffer back on a valid/ready byte stream for downstream transport or a file writer.

---
 rtl/compressed_stream_capture.sv | 253 +++++++++++++++++++++++++
 tb/tb_compressed_stream_capture.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_stream_capture.sv
// Captures the compressor byte stream into a buffer, checks the byte count against the reported size, then replays it on a valid/ready stream.
// Optional Adler-32 of the captured bytes is enabled with `define CAPTURE_ADLER32_EN.
module compressed_stream_capture #(
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_vld_i,
  input  logic [31:0]       in_size_i,
  input  logic              in_size_vld_i,
  input  logic              in_done_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic [31:0]       byte_count_o,
  output logic              busy_o,
  output logic              capture_done_o,
  output logic              size_mismatch_o,
  output logic              overflow_o,
  output logic [31:0]       adler32_o
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W = 32;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_CHECK, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]        size_q, size_d;
  logic               size_seen_q, size_seen_d;
  logic               mismatch_q, mismatch_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               out_v_q, out_v_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               skid_v_q, skid_v_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic               skid_last_q, skid_last_d;
  logic               pend_q, pend_d;
  logic               pend_last_q, pend_last_d;

  logic [DATA_W-1:0]  mem_q [DEPTH_P];
  logic [DATA_W-1:0]  rd_data_q;
  logic               mem_we_c;
  logic               rd_en_c;
  logic               pop_c;
  logic [1:0]         occ_c;

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    size_d      = size_q;
    size_seen_d = size_seen_q;
    mismatch_d  = mismatch_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    mem_we_c    = 1'b0;
    rd_en_c     = 1'b0;
    pop_c       = out_v_q && out_ready_i;
    occ_c       = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q) - 2'(pop_c);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_CAPTURE;
          wr_ptr_d    = '0;
          byte_cnt_d  = '0;
          size_seen_d = 1'b0;
          mismatch_d  = 1'b0;
          overflow_d  = 1'b0;
          done_d      = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (in_vld_i) begin
          if (wr_ptr_q != DEPTH_P) begin
            mem_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
          byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
        end
        if (in_size_vld_i) begin
          size_d      = in_size_i;
          size_seen_d = 1'b1;
        end
        if (in_done_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        mismatch_d = !size_seen_q || (size_q != byte_cnt_q);
        done_d     = 1'b1;
        rd_ptr_d   = '0;
        out_v_d    = 1'b0;
        out_last_d = 1'b0;
        skid_v_d   = 1'b0;
        state_d    = (wr_ptr_q == '0) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        // Issue a read only if the output register plus skid can absorb it
        if ((rd_ptr_q != wr_ptr_q) && (occ_c <= 2'd1)) begin
          rd_en_c     = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          pend_d      = 1'b1;
          pend_last_d = ((rd_ptr_q + PTR_W'(1)) == wr_ptr_q);
        end
        if (out_v_q && !pop_c) begin
          if (pend_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = rd_data_q;
            skid_last_d = pend_last_q;
          end
        end else if (skid_v_q) begin
          out_v_d     = 1'b1;
          out_data_d  = skid_data_q;
          out_last_d  = skid_last_q;
          skid_v_d    = pend_q;
          skid_data_d = rd_data_q;
          skid_last_d = pend_last_q;
        end else if (pend_q) begin
          out_v_d    = 1'b1;
          out_data_d = rd_data_q;
          out_last_d = pend_last_q;
        end else begin
          out_v_d    = 1'b0;
          out_last_d = 1'b0;
        end
        if (pop_c && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      size_q      <= '0;
      size_seen_q <= 1'b0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      size_q      <= size_d;
      size_seen_q <= size_seen_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  // Capture buffer: synchronous write, registered read
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data_i;
    if (rd_en_c)  rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

`ifdef CAPTURE_ADLER32_EN
  localparam logic [16:0] ADLER_MOD = 17'd65521;

  logic [15:0] adl_a_q, adl_a_d, adl_b_q, adl_b_d;
  logic [16:0] a_sum_c, b_sum_c;
  logic [15:0] a_nxt_c, b_nxt_c;

  // Running Adler-32; every accepted byte counts, including dropped overflow bytes
  always_comb begin
    a_sum_c = 17'(adl_a_q) + 17'(in_data_i);
    a_nxt_c = (a_sum_c >= ADLER_MOD) ? 16'(a_sum_c - ADLER_MOD) : a_sum_c[15:0];
    b_sum_c = 17'(adl_b_q) + 17'(a_nxt_c);
    b_nxt_c = (b_sum_c >= ADLER_MOD) ? 16'(b_sum_c - ADLER_MOD) : b_sum_c[15:0];
    adl_a_d = adl_a_q;
    adl_b_d = adl_b_q;
    if ((state_q == ST_IDLE) && start_i) begin
      adl_a_d = 16'd1;
      adl_b_d = 16'd0;
    end else if ((state_q == ST_CAPTURE) && in_vld_i) begin
      adl_a_d = a_nxt_c;
      adl_b_d = b_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adl_a_q <= 16'd1;
      adl_b_q <= 16'd0;
    end else begin
      adl_a_q <= adl_a_d;
      adl_b_q <= adl_b_d;
    end
  end

  assign adler32_o = {adl_b_q, adl_a_q};
`else
  assign adler32_o = '0;
`endif

  assign out_data_o      = out_data_q;
  assign out_valid_o     = out_v_q;
  assign out_last_o      = out_last_q;
  assign byte_count_o    = byte_cnt_q;
  assign busy_o          = busy_q;
  assign capture_done_o  = done_q;
  assign size_mismatch_o = mismatch_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_compressed_stream_capture.sv
// Randomized bench for compressed_stream_capture with a queue-based reference model of capture, size check, checksum and playback.
`timescale 1ns/1ps
module tb_compressed_stream_capture;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_vld;
  logic [31:0] in_size;
  logic        in_size_vld;
  logic        in_done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [31:0] byte_count;
  logic        busy;
  logic        capture_done;
  logic        size_mismatch;
  logic        overflow;
  logic [31:0] adler32;

  compressed_stream_capture #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .in_data_i(in_data), .in_vld_i(in_vld), .in_size_i(in_size),
    .in_size_vld_i(in_size_vld), .in_done_i(in_done),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .byte_count_o(byte_count), .busy_o(busy),
    .capture_done_o(capture_done), .size_mismatch_o(size_mismatch),
    .overflow_o(overflow), .adler32_o(adler32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];
  int exp_idx = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reset_adler();
`ifdef CAPTURE_ADLER32_EN
    return 32'd1;
`else
    return 32'd0;
`endif
  endfunction

  // Downstream ready: always, 1-0-0-1 pattern, or random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
          rdy_ph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Playback checker: order, last flag, stability under stall
  logic       prev_v = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_rdy) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid) chk("valid_while_busy", 32'(busy), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_idx < exp_q.size()) begin
          chk("play_data", 32'(out_data), 32'(exp_q[exp_idx]));
          chk("play_last", 32'(out_last), 32'(exp_idx == exp_q.size() - 1));
        end else begin
          chk("extra_byte", 32'(out_valid), 32'd0);
        end
        exp_idx++;
      end
      prev_v = out_valid; prev_rdy = out_ready;
      prev_data = out_data; prev_last = out_last;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_capture_done"}, 32'(capture_done), 32'd0);
    chk({tag, "_size_mismatch"}, 32'(size_mismatch), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_byte_count"}, byte_count, 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_adler32"}, adler32, reset_adler());
  endtask

  // size_mode: 0 no size report, 1 bogus early report then correct one with done, 2 report n+delta with done
  task automatic capture(input logic [7:0] bytes[$], input int size_mode, input int delta,
                         input bit done_with_last, input bit gaps, input bit start_in_drain);
    int n = bytes.size();
    int stored = (n > DEPTH) ? DEPTH : n;
    int a = 1;
    int b = 0;
    bit seen = 0;
    logic [31:0] last_size = 32'd0;
    logic [31:0] final_size;
    bit mm;
    final_size = (size_mode == 1) ? 32'(n) : 32'(n + delta);
    exp_q = {};
    for (int i = 0; i < stored; i++) exp_q.push_back(bytes[i]);
    exp_idx = 0;
    rdy_ph = 0;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk); #1;
      end
      in_vld = 1'b1;
      in_data = bytes[i];
      a = (a + int'(bytes[i])) % 65521;
      b = (b + a) % 65521;
      if (size_mode == 1 && i == 0) begin
        in_size_vld = 1'b1; in_size = 32'(n + 7); seen = 1; last_size = 32'(n + 7);
      end
      if (done_with_last && i == n - 1) begin
        in_done = 1'b1;
        if (size_mode != 0) begin
          in_size_vld = 1'b1; in_size = final_size; seen = 1; last_size = final_size;
        end
      end
      @(posedge clk); #1;
      in_vld = 1'b0; in_size_vld = 1'b0; in_done = 1'b0;
    end
    if (!(done_with_last && n > 0)) begin
      in_done = 1'b1;
      if (size_mode != 0) begin
        in_size_vld = 1'b1; in_size = final_size; seen = 1; last_size = final_size;
      end
      @(posedge clk); #1;
      in_done = 1'b0; in_size_vld = 1'b0;
    end
    @(posedge clk); #1;
    mm = !seen || (last_size != 32'(n));
    chk("capture_done", 32'(capture_done), 32'd1);
    chk("byte_count", byte_count, 32'(n));
    chk("size_mismatch", 32'(size_mismatch), 32'(mm));
    chk("overflow", 32'(overflow), 32'(n > DEPTH));
    chk("busy_after_check", 32'(busy), 32'(stored > 0));
`ifdef CAPTURE_ADLER32_EN
    chk("adler32", adler32, {16'(b), 16'(a)});
`else
    chk("adler32", adler32, 32'd0);
`endif
    if (start_in_drain) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int c = 0; c < 400 && busy; c++) @(negedge clk);
    chk("drain_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    chk("played_count", 32'(exp_idx), 32'(stored));
    chk("valid_after_drain", 32'(out_valid), 32'd0);
    if (start_in_drain) begin
      chk("drain_start_done_kept", 32'(capture_done), 32'd1);
      chk("drain_start_count_kept", byte_count, 32'(n));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_vld = 1'b0;
    in_size = 32'd0; in_size_vld = 1'b0; in_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Basic capture
    rdy_mode = 0;
    q = '{8'h78, 8'h9C, 8'h01, 8'h02, 8'h03};
    capture(q, 1, 0, 1'b0, 1'b0, 1'b0);
    chk("basic_count_literal", byte_count, 32'd5);
    chk("basic_mismatch_literal", 32'(size_mismatch), 32'd0);

    // Size mismatch, then missing size report
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    capture(q, 2, 2, 1'b0, 1'b0, 1'b0);
    chk("mismatch_literal", 32'(size_mismatch), 32'd1);
    capture(q, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("nosize_literal", 32'(size_mismatch), 32'd1);

    // Backpressure, start during drain ignored
    rdy_mode = 1;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(8'hA0 + i));
    capture(q, 1, 0, 1'b1, 1'b0, 1'b1);

    // Overflow
    rdy_mode = 2;
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom_range(0, 255)));
    capture(q, 1, 0, 1'b0, 1'b1, 1'b0);
    chk("ovf_literal", 32'(overflow), 32'd1);
    chk("ovf_count_literal", byte_count, 32'd20);

    // Zero-length capture
    q = {};
    capture(q, 1, 0, 1'b0, 1'b0, 1'b0);
    chk("zero_adler_literal", adler32, reset_adler());

    // Checksum of "Wikipedia"
    rdy_mode = 0;
    q = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    capture(q, 1, 0, 1'b1, 1'b0, 1'b0);
`ifdef CAPTURE_ADLER32_EN
    chk("wiki_adler_literal", adler32, 32'h11E60398);
`endif

    // Randomized captures
    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(0, 20);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      rdy_mode = $urandom_range(0, 2);
      capture(q, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a capture
    exp_q = {}; exp_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_vld = 1'b1; in_data = 8'h5A;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    in_vld = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_busy", 32'(busy), 32'd0);

    // Capture still works after the abort
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    capture(q, 1, 0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
